instr_stream_encoder: RTL

//   Inverse of the instruction decode/control path: packs per-field instruction descriptions into 32-bit words
//   (R / I / JI / JII formats) and streams them into instruction memory from a start address.

---
 rtl/instr_stream_encoder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_stream_encoder.sv
// Packs per-field instruction bundles into 32-bit R/I/JI/JII words and streams them into imem.
// Optional macro OPCODE_CHECK_EN enables per-kind opcode legality filtering (kind_err_o).
`timescale 1ns/1ps

module instr_stream_encoder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_last_i,
  input  logic [1:0]            in_kind_i,
  input  logic [4:0]            in_opcode_i,
  input  logic [4:0]            in_rd_i,
  input  logic [4:0]            in_rs_i,
  input  logic [4:0]            in_rt_i,
  input  logic [4:0]            in_shamt_i,
  input  logic [4:0]            in_aluop_i,
  input  logic [16:0]           in_imm_i,
  input  logic [26:0]           in_target_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_data_o,
  output logic                  imem_wren_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  wrap_err_o,
  output logic                  kind_err_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EntW = 34;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [1:0] KindR   = 2'd0;
  localparam logic [1:0] KindI   = 2'd1;
  localparam logic [1:0] KindJi  = 2'd2;
  localparam logic [1:0] KindJii = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wrap_err_q, wrap_err_d;
  logic                  kind_err_q, kind_err_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_data_q, imem_data_d;
  logic                  imem_wren_q, imem_wren_d;
  logic                  done_q, done_d;

  logic [EntW-1:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       fifo_wr_q, fifo_wr_d;
  logic [PtrW-1:0]       fifo_rd_q, fifo_rd_d;
  logic [PtrW:0]         fifo_cnt_q, fifo_cnt_d;
  logic                  fifo_full, fifo_empty;

  logic                  push, pop;
  logic [31:0]           enc_word;
  logic                  op_legal;
  logic [EntW-1:0]       head;
  logic [31:0]           head_word;
  logic                  head_last;
  logic                  head_skip;

  // ---------------------------------------------------------------------------
  // Field packing; fields unused by a format stay zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_word = '0;
    unique case (in_kind_i)
      KindR:   enc_word = {in_opcode_i, in_rd_i, in_rs_i, in_rt_i, in_shamt_i, in_aluop_i, 2'b00};
      KindI:   enc_word = {in_opcode_i, in_rd_i, in_rs_i, in_imm_i};
      KindJi:  enc_word = {in_opcode_i, in_target_i};
      KindJii: enc_word = {in_opcode_i, in_rd_i, 22'd0};
      default: enc_word = '0;
    endcase
  end

`ifdef OPCODE_CHECK_EN
  always_comb begin
    op_legal = 1'b0;
    unique case (in_kind_i)
      KindR:   op_legal = (in_opcode_i == 5'b00000);
      KindI:   op_legal = in_opcode_i inside {5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110};
      KindJi:  op_legal = in_opcode_i inside {5'b00001, 5'b00011, 5'b10110, 5'b10101};
      KindJii: op_legal = (in_opcode_i == 5'b00100);
      default: op_legal = 1'b0;
    endcase
  end
`else
  assign op_legal = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Input FIFO: entry = {skip, last, word}. Illegal bundles still travel through
  // the FIFO so that acceptance order and in_last handling stay uniform.
  // ---------------------------------------------------------------------------
  assign fifo_full  = (fifo_cnt_q == FIFO_DEPTH[PtrW:0]);
  assign fifo_empty = (fifo_cnt_q == '0);

  assign in_ready_o = (state_q == StLoad) && !fifo_full;
  assign push       = in_valid_i && in_ready_o;
  assign pop        = !fifo_empty;

  assign head      = fifo_mem_q[fifo_rd_q];
  assign head_word = head[31:0];
  assign head_last = head[32];
  assign head_skip = head[33];

  always_comb begin
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_wr_d = fifo_wr_q + 1'b1;
    end
    if (pop) begin
      fifo_rd_d = fifo_rd_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_mem_q[fifo_wr_q] <= {!op_legal, in_last_i, enc_word};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (push && in_last_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write port, pointer and status. The popped word is registered onto imem_*.
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d      = wptr_q;
    count_d     = count_q;
    wrap_err_d  = wrap_err_q;
    kind_err_d  = kind_err_q;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    imem_wren_d = 1'b0;
    done_d      = 1'b0;

    if (pop) begin
      if (!head_skip) begin
        imem_wren_d = 1'b1;
        imem_addr_d = wptr_q;
        imem_data_d = head_word;
        wptr_d      = wptr_q + 1'b1;
        if (&wptr_q) begin
          wrap_err_d = 1'b1;
        end
        if (!(&count_q)) begin
          count_d = count_q + 1'b1;
        end
      end else begin
        kind_err_d = 1'b1;
      end
      done_d = head_last;
    end

    if ((state_q == StIdle) && load_start_i) begin
      wptr_d     = start_addr_i;
      count_d    = '0;
      wrap_err_d = 1'b0;
      kind_err_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      fifo_cnt_q  <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      wrap_err_q  <= 1'b0;
      kind_err_q  <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      imem_wren_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      wrap_err_q  <= wrap_err_d;
      kind_err_q  <= kind_err_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      imem_wren_q <= imem_wren_d;
      done_q      <= done_d;
    end
  end

  // Strobe is gated by reset so a word registered just before reset never lands.
  assign imem_wren_o = imem_wren_q && !reset_i;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign count_o     = count_q;
  assign wrap_err_o  = wrap_err_q;
`ifdef OPCODE_CHECK_EN
  assign kind_err_o  = kind_err_q;
`else
  assign kind_err_o  = 1'b0;
`endif

endmodule
